// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo
//   AXI-Stream FIFO between the DMA stream master and the accelerator stream
//   slave. First-word fall-through storage of {tlast, tdata}, with optional
//   store-and-forward gating of m_tvalid until a complete packet is held.
//
// Ports
//   clk, rst_n        : clock, async active-low reset
//   clr               : synchronous flush (priority over push/pop)
//   sf_mode           : 0 = cut-through, 1 = store-and-forward (change only when empty)
//   s_tvalid/s_tdata/s_tlast/s_tready : upstream stream slave
//   m_tvalid/m_tdata/m_tlast/m_tready : downstream stream master
//   level             : stored beats, 0..DEPTH
//   pkt_cnt           : stored beats carrying tlast
//
// DEPTH must be a power of two (>= 4) and AW must equal log2(DEPTH).
module axis_stream_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          sf_mode,
  input  logic          s_tvalid,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic          m_tvalid,
  output logic [DW-1:0] m_tdata,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [AW:0]   level,
  output logic [AW:0]   pkt_cnt
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [DW:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt, r_pkt;
  logic          r_live;   // low in reset, high from the first clock after release

  logic          w_empty, w_full, w_push, w_pop;
  logic          w_push_last, w_pop_last;
  logic [DW:0]   w_head;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == L_FULL);
  assign w_head  = r_mem[r_rp];

  // Ready comes from registered state only: a pop while full does not open
  // a slot for a push in the same cycle.
  assign s_tready = r_live & ~w_full & ~clr;

  // Store-and-forward waits for a stored tlast, unless the FIFO is full:
  // a packet longer than DEPTH would otherwise never release.
  assign m_tvalid = ~w_empty & (~sf_mode | (r_pkt != '0) | w_full);
  assign m_tdata  = w_empty ? '0 : w_head[DW-1:0];
  assign m_tlast  = ~w_empty & w_head[DW];

  assign w_push      = s_tvalid & s_tready;
  assign w_pop       = m_tvalid & m_tready;
  assign w_push_last = w_push & s_tlast;
  assign w_pop_last  = w_pop & m_tlast;

  assign level   = r_cnt;
  assign pkt_cnt = r_pkt;

  // Storage is not reset; cnt == 0 masks any stale head.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {s_tlast, s_tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_pkt  <= '0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (clr) begin
        // Flush wins over any handshake in this cycle.
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_pkt <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + AW'(1);
        if (w_pop)  r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        r_pkt <= r_pkt + {{AW{1'b0}}, w_push_last} - {{AW{1'b0}}, w_pop_last};
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_fifo.sv
module tb_axis_stream_fifo;
  localparam int DW = 32, DEPTH = 16, AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, clr, sf_mode;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [DW-1:0] m_tdata;
  logic [AW:0]   level, pkt_cnt;

  axis_stream_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sf_mode(sf_mode),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .level(level), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [DW:0] q[$];       // expected beats {tlast, tdata}, in order
  int mcnt = 0, mpkt = 0;  // model occupancy / stored tlast count
  bit mlive = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard / model: checks registered-state outputs, then records the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin : sb
    bit push, pop, plast, exp_mv;
    logic [DW:0] hd;
    if (!rst_n) begin
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_level", level, 0);
      mcnt = 0; mpkt = 0; mlive = 1'b0; q.delete();
    end else begin
      exp_mv = (mcnt != 0) && (!sf_mode || mpkt != 0 || mcnt == DEPTH);
      chk("level", level, mcnt);
      chk("pkt_cnt", pkt_cnt, mpkt);
      chk("s_tready", s_tready, mlive && mcnt != DEPTH && !clr);
      chk("m_tvalid", m_tvalid, exp_mv);
      hd = (mcnt != 0 && q.size() > 0) ? q[0] : '0;
      chk("head", {m_tlast, m_tdata}, hd);
      push = s_tvalid && s_tready;
      pop  = m_tvalid && m_tready;
      if (clr) begin
        mcnt = 0; mpkt = 0; q.delete();
      end else begin
        if (push) chk("no_overflow", mcnt < DEPTH, 1);
        if (pop)  chk("no_underflow", mcnt > 0, 1);
        plast = pop && q.size() > 0 && q[0][DW];
        mcnt += int'(push) - int'(pop);
        mpkt += int'(push && s_tlast) - int'(plast);
        if (push) q.push_back({s_tlast, s_tdata});
      end
      mlive = 1'b1;
    end
  end

  // Monitor: pops and compares each accepted output beat.
  always @(negedge clk) begin : mon
    logic [DW:0] e;
    #1;
    if (rst_n && !clr && m_tvalid && m_tready) begin
      if (q.size() == 0) chk("mon_unexpected_beat", 1, 0);
      else begin
        e = q.pop_front();
        chk("mon_data", m_tdata, e[DW-1:0]);
        chk("mon_last", m_tlast, e[DW]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l);
    bit acc = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1;
    end
    if (!acc) chk("push_timeout", 0, 1);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    for (int n = 0; n < 200 && level != 0; n++) tick();
    chk(nm, level, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; clr = 0; sf_mode = 0; s_tvalid = 0; s_tdata = '0; s_tlast = 0; m_tready = 0;
    repeat (3) tick();
    rst_n = 1;
    chk("post_rst_level", level, 0);
    chk("post_rst_m_tvalid", m_tvalid, 0);
    chk("post_rst_m_tdata", m_tdata, 0);
    chk("post_rst_s_tready", s_tready, 0);
    tick();
    chk("live_s_tready", s_tready, 1);

    // 1: cut-through basic
    push_beat(32'h11, 0); push_beat(32'h22, 0); push_beat(32'h33, 1);
    chk("t1_level", level, 3);
    chk("t1_pkt", pkt_cnt, 1);
    chk("t1_head", m_tdata, 32'h11);
    m_tready = 1;
    tick(); chk("t1_d2", m_tdata, 32'h22); chk("t1_l2", m_tlast, 0);
    tick(); chk("t1_d3", m_tdata, 32'h33); chk("t1_l3", m_tlast, 1);
    tick(); chk("t1_level_end", level, 0); chk("t1_pkt_end", pkt_cnt, 0);
    chk("t1_mv_end", m_tvalid, 0); chk("t1_md_end", m_tdata, 0);
    m_tready = 0;

    // 2: full / backpressure, no same-cycle bypass
    for (int i = 0; i < 16; i++) push_beat(i, 0);
    chk("t2_level_full", level, 16);
    chk("t2_s_tready_full", s_tready, 0);
    s_tvalid = 1; s_tdata = 32'h10; s_tlast = 1;
    tick(); chk("t2_still_full", level, 16);
    m_tready = 1;
    tick(); m_tready = 0;
    chk("t2_level_15", level, 15);
    chk("t2_s_tready_back", s_tready, 1);
    tick(); s_tvalid = 0;
    chk("t2_level_refull", level, 16);
    chk("t2_pkt", pkt_cnt, 1);
    m_tready = 1; wait_empty("t2_drain"); m_tready = 0;

    // 3: store-and-forward
    sf_mode = 1; m_tready = 1;
    for (int i = 0; i < 5; i++) push_beat(32'h30 + i, 0);
    chk("t3_mv_hold", m_tvalid, 0);
    chk("t3_level5", level, 5);
    push_beat(32'h35, 1);
    chk("t3_mv_rise", m_tvalid, 1);
    chk("t3_pkt1", pkt_cnt, 1);
    chk("t3_level6", level, 6);
    repeat (5) tick();
    chk("t3_level1", level, 1); chk("t3_pkt_still1", pkt_cnt, 1);
    tick();
    chk("t3_level0", level, 0); chk("t3_pkt0", pkt_cnt, 0);
    m_tready = 0;

    // 4: oversize packet in store-and-forward
    for (int i = 0; i < 15; i++) push_beat(32'h40 + i, 0);
    chk("t4_mv_at15", m_tvalid, 0);
    push_beat(32'h4F, 0);
    chk("t4_mv_at16", m_tvalid, 1);
    chk("t4_level16", level, 16);
    m_tready = 1;
    for (int i = 0; i < 4; i++) push_beat(32'h50 + i, i == 3);
    wait_empty("t4_drain");
    m_tready = 0; sf_mode = 0;

    // 5: random concurrent traffic around level 8
    for (int i = 0; i < 8; i++) push_beat(32'h60 + i, i == 3 || i == 7);
    chk("t5_level8", level, 8);
    chk("t5_pkt2", pkt_cnt, 2);
    for (int i = 0; i < 1000; i++) begin
      s_tvalid = 1'($urandom_range(0, 1));
      s_tdata  = $urandom;
      s_tlast  = ($urandom_range(0, 3) == 0);
      m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    s_tvalid = 0; m_tready = 1;
    wait_empty("t5_drain");
    m_tready = 0;

    // 6: flush, then async reset mid-packet
    for (int i = 0; i < 7; i++) push_beat(32'h70 + i, i == 2);
    chk("t6_level7", level, 7);
    chk("t6_pkt1", pkt_cnt, 1);
    s_tvalid = 1; s_tdata = 32'h7F; s_tlast = 1; clr = 1;
    tick();
    clr = 0; s_tvalid = 0;
    chk("t6_clr_level", level, 0);
    chk("t6_clr_pkt", pkt_cnt, 0);
    chk("t6_clr_mv", m_tvalid, 0);
    push_beat(32'h80, 0); push_beat(32'h81, 0);
    #1 rst_n = 0;
    #1;
    chk("t6_rst_mv", m_tvalid, 0);
    chk("t6_rst_sr", s_tready, 0);
    chk("t6_rst_level", level, 0);
    tick(); tick();
    rst_n = 1;
    chk("t6_rel_sr", s_tready, 0);
    tick();
    chk("t6_live_sr", s_tready, 1);
    m_tready = 1;
    push_beat(32'h90, 0); push_beat(32'h91, 1);
    wait_empty("t6_drain");
    chk("t6_pkt_end", pkt_cnt, 0);
    m_tready = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
